// File: rtl/afp3_rmw_pkg.sv
// Shared types and constants for the 1024x4 status-RAM read-modify-write controller.
package afp3_rmw_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned RAM_DEPTH = 1024;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Set is applied after clear, so set wins on a shared bit.
    function automatic logic [3:0] rmw_apply(input logic [3:0] old_val,
                                             input logic [3:0] set_mask,
                                             input logic [3:0] clr_mask);
        return (old_val & ~clr_mask) | set_mask;
    endfunction

endpackage

// File: rtl/afp3_ram1024x004.sv
// Simple dual-port 1024x4 RAM; a read colliding with a same-address write returns X.
module afp3_ram1024x004
    import afp3_rmw_pkg::*;
(
    input  logic       clk,
    input  logic       wren,
    input  logic [9:0] wrad,
    input  logic [3:0] data,
    input  logic       rden,
    input  logic [9:0] rdad,
    output logic [3:0] q
);

    logic [3:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wrad] <= data;
        end
        if (rden) begin
            q <= (wren && (wrad == rdad)) ? 4'bxxxx : mem[rdad];
        end
    end

endmodule

// File: rtl/afp3_rr_arb2.sv
// Two-requester round-robin arbiter; the registered pointer remembers the last winner.
module afp3_rr_arb2
    import afp3_rmw_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_q;

    always_comb begin
        gnt_a = en & req_a & (~req_b | (last_q == SRC_B));
        gnt_b = en & req_b & (~req_a | (last_q == SRC_A));
    end

    // Reset value makes A the preferred winner of the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= SRC_B;
        end else if (gnt_a | gnt_b) begin
            last_q <= gnt_b ? SRC_B : SRC_A;
        end
    end

endmodule

// File: rtl/afp3_ram1024x004_rmw_ctl.sv
// Init sweep, round-robin A/B arbitration and two-stage read-modify-write with
// write-to-read forwarding around the RAM's same-address collision.
module afp3_ram1024x004_rmw_ctl
    import afp3_rmw_pkg::*;
#(
    parameter logic [3:0]  INIT_VAL   = 4'h0,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DEPTH_LOG2-1:0] a_addr,
    input  logic [3:0]            a_set,
    input  logic [3:0]            a_clr,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DEPTH_LOG2-1:0] b_addr,
    input  logic [3:0]            b_set,
    input  logic [3:0]            b_clr,
    output logic                  rsp_valid,
    output logic                  rsp_src,
    output logic [DEPTH_LOG2-1:0] rsp_addr,
    output logic [3:0]            rsp_old,
    output logic [3:0]            rsp_new,
    output logic                  ram_wren,
    output logic [DEPTH_LOG2-1:0] ram_wrad,
    output logic [3:0]            ram_data,
    output logic                  ram_rden,
    output logic [DEPTH_LOG2-1:0] ram_rdad,
    input  logic [3:0]            ram_q
);

    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = {DEPTH_LOG2{1'b1}};

    state_e                state;
    logic [DEPTH_LOG2-1:0] cnt;
    logic                  s1_valid;
    logic                  s1_src;
    logic [DEPTH_LOG2-1:0] s1_addr;
    logic [3:0]            s1_set;
    logic [3:0]            s1_clr;
    logic                  fwd_valid;
    logic [DEPTH_LOG2-1:0] fwd_addr;
    logic [3:0]            fwd_data;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  arb_en;
    logic                  fwd_hit;
    logic [3:0]            old_val;
    logic [3:0]            new_val;

    assign arb_en = (state == ST_RUN) && !init_req;

    afp3_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (arb_en),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    always_comb begin
        a_ready  = gnt_a;
        b_ready  = gnt_b;
        ram_rden = gnt_a | gnt_b;
        ram_rdad = gnt_b ? b_addr : a_addr;
        // ram_q is X on a back-to-back same-address read, so it must lose to the forward.
        fwd_hit  = fwd_valid && (fwd_addr == s1_addr);
        old_val  = fwd_hit ? fwd_data : ram_q;
        new_val  = rmw_apply(old_val, s1_set, s1_clr);
        if (state == ST_INIT) begin
            ram_wren = 1'b1;
            ram_wrad = cnt;
            ram_data = INIT_VAL;
        end else begin
            ram_wren = s1_valid;
            ram_wrad = s1_addr;
            ram_data = new_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            s1_valid  <= 1'b0;
            s1_src    <= SRC_A;
            s1_addr   <= '0;
            s1_set    <= '0;
            s1_clr    <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_src   <= SRC_A;
            rsp_addr  <= '0;
            rsp_old   <= '0;
            rsp_new   <= '0;
        end else begin
            s1_valid <= gnt_a | gnt_b;
            if (gnt_a | gnt_b) begin
                s1_src  <= gnt_b ? SRC_B : SRC_A;
                s1_addr <= gnt_b ? b_addr : a_addr;
                s1_set  <= gnt_b ? b_set : a_set;
                s1_clr  <= gnt_b ? b_clr : a_clr;
            end
            fwd_valid <= s1_valid;
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                fwd_addr <= s1_addr;
                fwd_data <= new_val;
                rsp_src  <= s1_src;
                rsp_addr <= s1_addr;
                rsp_old  <= old_val;
                rsp_new  <= new_val;
            end
            unique case (state)
                ST_INIT: begin
                    cnt <= cnt + DEPTH_LOG2'(1);
                    if (cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state     <= ST_DRAIN;
                        init_done <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/afp3_ram1024x004_rmw_ctl.md
Name: afp3_ram1024x004_rmw_ctl

Overview:
Sequencer and arbiter for one 1024x4 simple-dual-port block RAM holding per-entry 4-bit status. After reset it sweeps the RAM to a known value. It then serves two requesters, A and B, with round-robin read-modify-write operations (set/clear bit masks), one operation per cycle. It forwards internally around the RAM's same-address read/write collision, where the RAM returns X.

Parameters:
INIT_VAL, 4'h0, value written to every entry during the init sweep
DEPTH_LOG2, 10, address width; the RAM depth is 2**DEPTH_LOG2 = 1024

Ports:
clk  in  1  single clock; all logic is on its rising edge
reset_n  in  1  asynchronous, active-low reset
init_req  in  1  pulse that requests a re-sweep of the RAM to INIT_VAL
init_done  out  1  high when the sweep is complete and requests are accepted
a_valid  in  1  requester A has an operation
a_ready  out  1  requester A's operation is accepted this cycle
a_addr  in  10  entry address for A
a_set  in  4  bits to set for A
a_clr  in  4  bits to clear for A
b_valid, b_ready, b_addr, b_set, b_clr  same as A, for requester B
rsp_valid  out  1  one-cycle response strobe
rsp_src  out  1  0 = A, 1 = B
rsp_addr  out  10  address of the completed operation
rsp_old  out  4  entry value before the update
rsp_new  out  4  entry value after the update
ram_wren  out  1  RAM write enable
ram_wrad  out  10  RAM write address
ram_data  out  4  RAM write data
ram_rden  out  1  RAM read enable
ram_rdad  out  10  RAM read address
ram_q  in  4  RAM read data; valid one cycle after ram_rden

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to INIT; sweep counter = 0.
  - init_done=0; a_ready=b_ready=0; rsp_valid=0; rsp_* data=0.
  - Stage-1 valid=0; forward-valid=0; round-robin pointer favours A.
- State INIT:
  - ram_wren=1, ram_wrad=counter, ram_data=INIT_VAL; counter increments every cycle.
  - ram_rden=0; readies are 0.
  - After the write to 1023, go to RUN on the next edge. The sweep takes exactly 1024 cycles.
  - init_done is registered and rises on entry to RUN.
  - init_req is ignored while in INIT.
- State RUN, stage 0 (grant, combinational):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted; the pointer updates on each grant.
  - x_ready = grant. The handshake is x_valid & x_ready.
  - A requester must hold addr/set/clr stable until accepted. The block never issues ready without the matching valid.
  - On a grant: ram_rden=1, ram_rdad=granted addr. Stage-1 registers capture src, addr, set and clr, and s1_valid is set.
- State RUN, stage 1 (cycle T+1 for a grant at T):
  - old = fwd_hit ? fwd_data : ram_q.
  - fwd_hit = fwd_valid & (fwd_addr == s1_addr). The forward register holds the value written in the previous cycle.
  - new = (old & ~clr) | set; set wins over clr on the same bit.
  - Write-back: ram_wren=1, ram_wrad=s1_addr, ram_data=new.
  - The forward register captures the address and new value; fwd_valid = s1_valid.
- Collision handling:
  - A same-address operation granted back-to-back reads the RAM during that address's write, and the RAM returns X.
  - The forward path guarantees correct data. ram_q must never propagate to rsp_* when fwd_hit=1.
  - A write issued two or more cycles earlier is already in the RAM and needs no forwarding.
- Response: registered, so rsp_valid is high on cycle T+2 with src, addr, old and new. Throughput is 1 operation per cycle.
- Re-initialisation (init_req=1 in RUN):
  - Stop granting immediately and go to DRAIN.
  - DRAIN lasts until s1_valid=0 (at most 1 cycle), then enters INIT with counter=0 and init_done=0.
  - A pending response still issues normally.
- Reset during any state aborts all work. No partial response is emitted after reset deasserts.

Decomposition:
- Shared package afp3_rmw_pkg:
  - state encoding ST_INIT / ST_RUN / ST_DRAIN
  - RAM_DEPTH = 1024
  - SRC_A = 1'b0, SRC_B = 1'b1
- One natural sub-module: afp3_rr_arb2, a two-requester round-robin arbiter with a registered last-grant pointer. The RAM stays outside the block; afp3_ram1024x004 is instantiated next to it in the bench and in the top level.

Test Plan:
- Init sweep: release reset, INIT_VAL=4'h0.
  - Required: ram_wren high for exactly 1024 cycles with addresses 0..1023, then init_done=1.
  - Readback through A with set=0, clr=0 on addresses 0, 511 and 1023 returns old=0.
- Single RMW: A addr 10'h005 set=4'b0011, then addr 5 set=4'b1000 clr=4'b0001, two cycles apart.
  - Required: rsp old=0/new=3, then old=3/new=4'b1010.
- Back-to-back collision: A issues addr 7 set=1, set=2, set=4 on consecutive cycles.
  - Required: responses old=0/new=1, 1/3, 3/7, with no X on rsp_old.
- Arbitration: A and B continuously valid to different addresses for 6 cycles.
  - Required: grants alternate A,B,A,B,A,B and rsp_src alternates.
  - B alone is then granted every cycle.
- Mask conflict: set=4'b1111 and clr=4'b1111 on an entry holding 0.
  - Required: new=4'hF.
- init_req mid-traffic: assert init_req while A is streaming.
  - Required: a_ready drops the same cycle, the pending response still completes, and a 1024-cycle sweep follows.
  - After the sweep, a read of a previously written address returns 0.
  - Async reset asserted mid-sweep restarts the sweep at address 0.
